// File: rtl/ram_fifo_ctrl_pkg.sv
// ram_fifo_ctrl_pkg: shared grant and RAM direction encodings for the RAM FIFO controller
package ram_fifo_ctrl_pkg;
  localparam logic GRANT_W   = 1'b1;
  localparam logic GRANT_R   = 1'b0;
  localparam logic RAM_WRITE = 1'b1;
  localparam logic RAM_READ  = 1'b0;
endpackage

// File: rtl/ram_fifo_ctrl_arbiter.sv
// ram_port_arbiter: round-robin grant of the single RAM port between upstream writes and output fetches
module ram_port_arbiter
  import ram_fifo_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic write_want,
  input  logic fetch_want,
  output logic wr_grant,
  output logic rd_grant,
  output logic wr_block
);
  logic last_grant_q, last_grant_d;
  always_comb begin
    wr_block     = fetch_want && last_grant_q == GRANT_W;
    wr_grant     = rst_n && write_want && !wr_block;
    rd_grant     = rst_n && fetch_want && !wr_grant;
    last_grant_d = wr_grant ? GRANT_W : rd_grant ? GRANT_R : last_grant_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) last_grant_q <= GRANT_R;
    else last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: streams a valid/ready write port into a single-port RAM and replays it in FIFO order
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          CLK_,
  input  logic          RST_,
  input  logic          WR_VALID,
  output logic          WR_READY,
  input  logic [DW-1:0] WR_DATA,
  output logic          RD_VALID,
  input  logic          RD_READY,
  output logic [DW-1:0] RD_DATA,
  output logic          R_W_,
  output logic [AW-1:0] ADDR_,
  output logic [DW-1:0] RAM_DIN,
  input  logic [DW-1:0] RAM_DOUT,
  output logic [AW:0]   COUNT,
  output logic          FULL,
  output logic          EMPTY
);
  localparam int DEPTH = 2 ** AW;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ob_valid_q, ob_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          fetch_want, write_want, wr_grant, rd_grant, wr_block;
  always_comb begin
    FULL       = count_q == (AW+1)'(DEPTH);
    EMPTY      = count_q == '0;
    fetch_want = !EMPTY && (!ob_valid_q || RD_READY);
    write_want = WR_VALID && !FULL;
  end
  ram_port_arbiter u_arb (
    .clk       (CLK_),
    .rst_n     (RST_),
    .write_want(write_want),
    .fetch_want(fetch_want),
    .wr_grant  (wr_grant),
    .rd_grant  (rd_grant),
    .wr_block  (wr_block)
  );
  // Idle cycles still present rd_ptr so the RAM read path is already pointed at the next word
  always_comb begin
    WR_READY   = RST_ && !FULL && !wr_block;
    R_W_       = wr_grant ? RAM_WRITE : RAM_READ;
    ADDR_      = wr_grant ? wr_ptr_q : rd_ptr_q;
    RAM_DIN    = WR_DATA;
    wr_ptr_d   = wr_grant ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = rd_grant ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = wr_grant ? count_q + 1'b1 : rd_grant ? count_q - 1'b1 : count_q;
    ob_valid_d = rd_grant || (ob_valid_q && !RD_READY);
    rd_data_d  = rd_grant ? RAM_DOUT : rd_data_q;
    RD_VALID   = ob_valid_q;
    RD_DATA    = rd_data_q;
    COUNT      = count_q;
  end
  always_ff @(posedge CLK_) begin
    if (!RST_) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ob_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ob_valid_q <= ob_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed checks of the RAM FIFO controller against a behavioural 4x8 RAM
module tb_ram_fifo_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, rd_valid, r_w, full, empty;
  logic [7:0] rd_data, ram_din, ram_dout;
  logic [1:0] addr;
  logic [2:0] count;
  logic [7:0] mem [4];
  logic [1:0] exp_wa = 2'd0;
  logic [7:0] in_q [$];
  logic [7:0] exp_q [$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.AW(2), .DW(8)) dut (
    .CLK_(clk), .RST_(rst_n), .WR_VALID(wr_valid), .WR_READY(wr_ready), .WR_DATA(wr_data),
    .RD_VALID(rd_valid), .RD_READY(rd_ready), .RD_DATA(rd_data), .R_W_(r_w), .ADDR_(addr),
    .RAM_DIN(ram_din), .RAM_DOUT(ram_dout), .COUNT(count), .FULL(full), .EMPTY(empty)
  );

  always @(posedge clk) if (r_w) mem[addr] <= ram_din;
  assign ram_dout = mem[addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    wr_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_wa = 2'd0;
  endtask

  // Feeds in_q through the write port and checks every consumed word against exp_q
  task automatic drain(input int max);
    int n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < max) begin
      wr_valid = in_q.size() > 0;
      wr_data = wr_valid ? in_q[0] : 8'h00;
      #1;
      if (rd_ready && rd_valid) begin
        if (exp_q.size() > 0) chk("rd_data", rd_data, exp_q.pop_front());
        else chk("rd_extra", rd_valid, 0);
      end
      if (wr_valid && wr_ready) begin
        chk("wr_addr", {r_w, addr}, {1'b1, exp_wa});
        exp_wa++;
        void'(in_q.pop_front());
      end
      @(posedge clk);
      #1;
      n++;
    end
    wr_valid = 1'b0;
    chk("drain_timeout", n < max, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    #1;
    chk("rst_wr_ready_comb", wr_ready, 0);
    chk("rst_rw_comb", r_w, 0);
    tick();
    tick();
    chk("rst_rw", r_w, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);

    rst_n = 1'b1;
    wr_data = 8'hAA;
    #1;
    chk("single_rw", r_w, 1);
    chk("single_addr", addr, 0);
    chk("single_wr_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    exp_wa = 2'd1;
    chk("single_count", count, 1);
    chk("single_not_yet_valid", rd_valid, 0);
    tick();
    chk("single_rd_valid", rd_valid, 1);
    chk("single_rd_data", rd_data, 8'hAA);
    chk("single_count_after", count, 0);
    tick();
    chk("single_consumed", rd_valid, 0);
    chk("single_empty", empty, 1);

    rd_ready = 1'b0;
    in_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drain(40);
    chk("fill_count", count, 4);
    chk("fill_full", full, 1);
    chk("fill_wr_ready", wr_ready, 0);
    chk("fill_rd_valid", rd_valid, 1);
    chk("fill_rd_data", rd_data, 8'h11);
    wr_valid = 1'b1;
    wr_data = 8'h66;
    #1;
    chk("full_wr_ready", wr_ready, 0);
    chk("full_rw", r_w, 0);
    tick();
    chk("full_count_hold", count, 4);
    chk("full_rd_data_stable", rd_data, 8'h11);
    rd_ready = 1'b1;
    in_q = '{8'h66};
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    drain(60);
    chk("fill_end_rd_valid", rd_valid, 0);
    chk("fill_end_empty", empty, 1);

    do_reset();
    rd_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_q.push_back(8'(i));
      exp_q.push_back(8'(i));
    end
    drain(80);
    chk("wrap_end_rd_valid", rd_valid, 0);
    chk("wrap_end_count", count, 0);

    do_reset();
    rd_ready = 1'b0;
    wr_valid = 1'b1;
    wr_data = 8'hA1;
    #1;
    chk("ct_first_wr_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    tick();
    wr_valid = 1'b1;
    wr_data = 8'hB2;
    tick();
    wr_data = 8'hC3;
    tick();
    wr_valid = 1'b0;
    chk("ct_setup_count", count, 2);
    rd_ready = 1'b1;
    tick();
    chk("ct_setup_rd_data", rd_data, 8'hB2);
    wr_valid = 1'b1;
    wr_data = 8'hD4;
    #1;
    chk("ct_rw_0", r_w, 1);
    tick();
    wr_data = 8'hE5;
    #1;
    chk("ct_rw_1", r_w, 0);
    tick();
    #1;
    chk("ct_rw_2", r_w, 1);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("ct_rw_3", r_w, 0);
    tick();
    chk("ct_rd_data", rd_data, 8'hD4);
    chk("ct_count", count, 1);
    exp_q = '{8'hD4, 8'hE5};
    drain(20);
    chk("ct_end_empty", empty, 1);

    do_reset();
    rd_ready = 1'b0;
    in_q = '{8'h31, 8'h32, 8'h33};
    drain(20);
    chk("mid_count", count, 2);
    chk("mid_rd_valid", rd_valid, 1);
    rst_n = 1'b0;
    wr_valid = 1'b1;
    wr_data = 8'h77;
    #1;
    chk("mid_rst_rw", r_w, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    tick();
    rst_n = 1'b1;
    wr_valid = 1'b0;
    exp_wa = 2'd0;
    chk("mid_count_cleared", count, 0);
    chk("mid_rd_valid_cleared", rd_valid, 0);
    chk("mid_rd_data_cleared", rd_data, 8'h00);
    chk("mid_empty", empty, 1);
    rd_ready = 1'b1;
    in_q = '{8'h5A};
    exp_q = '{8'h5A};
    drain(20);
    tick();
    chk("mid_alone_rd_valid", rd_valid, 0);
    chk("mid_alone_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
